matrix_scan_ctrl: RTL

Parametrised, self-clocked LED-matrix display controller for the irrigation panel. It generates its own row scan and image-alternation timing, and round-robins among all currently asserted status requests: water level (critical/low/medium/high) and irrigation type (sprinkler/drip). Each image can optionally blink. It sits between the moisture/irrigation status logic and the physical 7x5 matrix pins, replacing externally supplied scan and image-select counters.

---
 rtl/matrix_pkg.sv | 22 ++
 rtl/matrix_scan_ctrl_if.sv | 15 +
 rtl/matrix_scan_ctrl_glyph_rom.sv | 13 +
 rtl/matrix_scan_ctrl.sv | 79 +++++++
 4 files changed

// File: rtl/matrix_pkg.sv
// matrix_pkg: image indices and 7x5 glyph constants for the irrigation status matrix
package matrix_pkg;
  localparam int G_ROWS = 7;
  localparam int G_COLS = 5;
  localparam int IMG_COUNT = 6;
  localparam int IMG_CRIT = 0;
  localparam int IMG_BAIX = 1;
  localparam int IMG_MEDI = 2;
  localparam int IMG_ALTO = 3;
  localparam int IMG_ASPE = 4;
  localparam int IMG_GOTE = 5;
  typedef logic [G_ROWS-1:0][G_COLS-1:0] glyph_t;
  typedef logic [IMG_COUNT-1:0][G_ROWS-1:0][G_COLS-1:0] glyph_set_t;
  // Rows listed bottom (row 6) first so that glyph[r] is row r
  localparam glyph_t G_CRIT = {5'b00100, 5'b00000, 5'b00100, 5'b00100, 5'b00100, 5'b00100, 5'b00100};
  localparam glyph_t G_BAIX = {5'b11111, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000};
  localparam glyph_t G_MEDI = {5'b10001, 5'b10001, 5'b10001, 5'b11111, 5'b10001, 5'b01010, 5'b00100};
  localparam glyph_t G_ALTO = {5'b11111, 5'b10001, 5'b10001, 5'b10001, 5'b10001, 5'b10001, 5'b11111};
  localparam glyph_t G_ASPE = {5'b00100, 5'b00100, 5'b10101, 5'b01110, 5'b11111, 5'b01110, 5'b10101};
  localparam glyph_t G_GOTE = {5'b01110, 5'b11111, 5'b11111, 5'b01110, 5'b01110, 5'b00100, 5'b00100};
  localparam glyph_set_t GLYPHS = {G_GOTE, G_ASPE, G_ALTO, G_MEDI, G_BAIX, G_CRIT};
endpackage

// File: rtl/matrix_scan_ctrl_if.sv
// matrix_scan_ctrl_if: status requests in, matrix pins and display status out
interface matrix_scan_ctrl_if #(
  parameter int ROWS = 7,
  parameter int COLS = 5,
  parameter int NIMG = 6
);
  logic [NIMG-1:0] img_req;
  logic [ROWS-1:0] lin;
  logic [COLS-1:0] col;
  logic [$clog2(NIMG)-1:0] cur_img;
  logic cur_valid;
  logic frame_tick;
  modport master (output img_req, input lin, col, cur_img, cur_valid, frame_tick);
  modport slave (input img_req, output lin, col, cur_img, cur_valid, frame_tick);
endinterface

// File: rtl/matrix_scan_ctrl_glyph_rom.sv
// glyph_rom: combinational lookup of one glyph row by image index
module glyph_rom
  import matrix_pkg::*;
#(
  parameter int IW = 3,
  parameter int RW = 3
) (
  input  logic [IW-1:0]     img,
  input  logic [RW-1:0]     row,
  output logic [G_COLS-1:0] bits
);
  assign bits = GLYPHS[img][row];
endmodule

// File: rtl/matrix_scan_ctrl.sv
// matrix_scan_ctrl: self-timed row scan with round-robin image selection and blink
module matrix_scan_ctrl
  import matrix_pkg::*;
#(
  parameter int ROWS = 7,
  parameter int COLS = 5,
  parameter int NIMG = 6,
  parameter int SCAN_DIV = 4,
  parameter int ALT_FRAMES = 3,
  parameter int BLINK_FRAMES = 2,
  parameter logic [NIMG-1:0] BLINK_MASK = 6'b000001
) (
  input logic clk,
  input logic rst,
  matrix_scan_ctrl_if.slave bus
);
  localparam int IW = $clog2(NIMG);
  localparam int RW = $clog2(ROWS);
  localparam int PW = $clog2(SCAN_DIV);
  localparam int DW = $clog2(ALT_FRAMES + 1);
  localparam int BW = $clog2(BLINK_FRAMES + 1);
  logic [PW-1:0] pre;
  logic [RW-1:0] row;
  logic [DW-1:0] dwell;
  logic [BW-1:0] bcnt;
  logic [IW-1:0] sel, nxt;
  logic [COLS-1:0] glyph;
  logic phase, valid, tick, any, sw, chg, bwrap;
  // Nearest asserted request strictly after s, wrapping; s itself is the last candidate
  function automatic logic [IW-1:0] next_after(input logic [NIMG-1:0] req, input logic [IW-1:0] s);
    logic [IW-1:0] r, j;
    r = s;
    for (int i = NIMG; i >= 1; i--) begin
      j = IW'((int'(s) + i) % NIMG);
      if (req[j]) r = j;
    end
    return r;
  endfunction
  glyph_rom #(.IW(IW), .RW(RW)) rom (.img(sel), .row(row), .bits(glyph));
  always_comb begin
    any = |bus.img_req;
    tick = pre == PW'(SCAN_DIV - 1) && row == RW'(ROWS - 1);
    nxt = next_after(bus.img_req, valid ? sel : IW'(NIMG - 1));
    sw = !valid || !bus.img_req[sel] || dwell == DW'(ALT_FRAMES - 1);
    chg = !any || (sw && (!valid || nxt != sel));
    bwrap = bcnt == BW'(BLINK_FRAMES - 1);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pre <= '0;
      row <= '0;
      dwell <= '0;
      bcnt <= '0;
      phase <= 1'b1;
      sel <= '0;
      valid <= 1'b0;
      bus.lin <= '1;
      bus.col <= '0;
      bus.cur_img <= '0;
      bus.cur_valid <= 1'b0;
      bus.frame_tick <= 1'b0;
    end else begin
      pre <= (pre == PW'(SCAN_DIV - 1)) ? '0 : pre + 1'b1;
      if (pre == PW'(SCAN_DIV - 1)) row <= (row == RW'(ROWS - 1)) ? '0 : row + 1'b1;
      if (tick) begin
        valid <= any;
        if (any && sw) sel <= nxt;
        dwell <= (!any || sw) ? '0 : dwell + 1'b1;
        bcnt <= (chg || bwrap) ? '0 : bcnt + 1'b1;
        phase <= chg ? 1'b1 : phase ^ bwrap;
      end
      // Outputs follow counter state by one cycle; prescaler 0 is the anti-ghost blank slot
      bus.lin <= (valid && pre != '0) ? ~(ROWS'(1) << row) : '1;
      bus.col <= (valid && pre != '0 && (phase || !BLINK_MASK[sel])) ? glyph : '0;
      bus.cur_img <= sel;
      bus.cur_valid <= valid;
      bus.frame_tick <= tick;
    end
endmodule
